// File: rtl/uart_imul_cmd_if.sv
// Byte-wide valid/ready stream used between the UART cores and the
// command engine.
//   tdata  : byte being transferred
//   tvalid : producer has a byte
//   tready : consumer can take it; transfer happens on tvalid && tready
interface uart_imul_cmd_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_imul_cmd.sv
// UART-driven integer multiplier.
// A frame is an opcode byte followed by A and B (OperandBytes each, MSB
// first). The product is computed by a shift-add multiplier and the
// selected half is returned over the UART, MSB first. Bad opcodes get a
// single 0xEE reply.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   rx_i    : UART receive line (idle high)
//   tx_o    : UART transmit line (idle high)
//   busy_o  : engine is not idle
//   abort_o : one-cycle pulse when a partial frame times out
//   drop_o  : one-cycle pulse for each byte discarded while busy

// 8N1 receiver; one bit lasts 8*prescale clocks.
//   clk, rst (active high, synchronous), prescale, rxd, m_axis (byte out)
module uart_rx (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     prescale,
    input  logic            rxd,
    uart_imul_cmd_if.master m_axis
);
    logic [1:0]  rxd_sync;
    logic [18:0] tmr;
    logic [18:0] bit_period;
    logic [18:0] half_period;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        active;

    assign bit_period  = {prescale, 3'b000};
    assign half_period = {1'b0, prescale, 2'b00};

    // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_sync      <= 2'b11;
            tmr           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            active        <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
        end else begin
            rxd_sync <= {rxd_sync[0], rxd};
            if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            if (!active) begin
                if (!rxd_sync[1]) begin
                    active  <= 1'b1;
                    bit_cnt <= '0;
                    tmr     <= half_period - 19'd1;
                end
            end else if (tmr != '0) begin
                tmr <= tmr - 19'd1;
            end else begin
                tmr <= bit_period - 19'd1;
                if (bit_cnt == 4'd0) begin
                    // start bit high again at mid-bit: glitch, not a frame
                    if (rxd_sync[1]) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= 4'd1;
                    end
                end else if (bit_cnt <= 4'd8) begin
                    shift   <= {rxd_sync[1], shift[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else begin
                    active <= 1'b0;
                    if (rxd_sync[1]) begin
                        m_axis.tdata  <= shift;
                        m_axis.tvalid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// 8N1 transmitter; one bit lasts 8*prescale clocks.
//   clk, rst (active high, synchronous), prescale, txd, s_axis (byte in)
module uart_tx (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    prescale,
    output logic           txd,
    uart_imul_cmd_if.slave s_axis
);
    logic [8:0]  shift;
    logic [3:0]  bit_cnt;
    logic [18:0] tmr;
    logic [18:0] bit_period;
    logic        active;

    assign bit_period    = {prescale, 3'b000};
    assign s_axis.tready = !active;

    // shift holds {stop, data}; 9 shifts after the start bit end on the stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            txd     <= 1'b1;
            shift   <= '1;
            bit_cnt <= '0;
            tmr     <= '0;
            active  <= 1'b0;
        end else if (!active) begin
            if (s_axis.tvalid) begin
                active  <= 1'b1;
                txd     <= 1'b0;
                shift   <= {1'b1, s_axis.tdata};
                bit_cnt <= 4'd9;
                tmr     <= bit_period - 19'd1;
            end
        end else if (tmr != '0) begin
            tmr <= tmr - 19'd1;
        end else if (bit_cnt != 4'd0) begin
            txd     <= shift[0];
            shift   <= {1'b1, shift[8:1]};
            bit_cnt <= bit_cnt - 4'd1;
            tmr     <= bit_period - 19'd1;
        end else begin
            active <= 1'b0;
        end
    end
endmodule

// state    | meaning
// IDLE     | waiting for an opcode byte
// OPERANDS | collecting 2*OperandBytes operand bytes, inter-byte timer running
// MUL      | W shift-add cycles, then one sign-correction cycle
// SEND     | handing OperandBytes result bytes to the transmitter
// NAK      | handing the single 0xEE reply to the transmitter
module uart_imul_cmd #(
    parameter int DesiredBaudRate = 115_200,
    parameter int ClockFrequency  = 12_000_000,
    parameter int OperandBytes    = 4,
    parameter int TimeoutCycles   = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic tx_o,
    output logic busy_o,
    output logic abort_o,
    output logic drop_o
);
    localparam int W    = 8 * OperandBytes;
    localparam int CntW = $clog2(2 * OperandBytes + 1);
    localparam int MulW = $clog2(W + 1);
    localparam int TmrW = $clog2(TimeoutCycles + 1);

    localparam longint PrescaleL = (longint'(ClockFrequency) + 4 * longint'(DesiredBaudRate))
                                   / (8 * longint'(DesiredBaudRate));
    localparam longint ActualX8  = 8 * PrescaleL * longint'(DesiredBaudRate);
    localparam longint BaudErr   = (ActualX8 > longint'(ClockFrequency))
                                   ? ActualX8 - longint'(ClockFrequency)
                                   : longint'(ClockFrequency) - ActualX8;
    localparam logic [15:0] Prescale = 16'(PrescaleL);

    localparam logic [CntW-1:0] LastOpByte = CntW'(2 * OperandBytes - 1);
    localparam logic [CntW-1:0] LastTxByte = CntW'(OperandBytes - 1);
    localparam logic [TmrW-1:0] TmrLoad    = TmrW'(TimeoutCycles - 1);

    // relative baud error above 5 %: 20*|actual - clk| > actual
    if (20 * BaudErr > ActualX8) begin : g_baud_err
        $error("uart_imul_cmd: baud rate error above 5 percent");
    end
    if (OperandBytes < 1 || OperandBytes > 8) begin : g_ob_err
        $error("uart_imul_cmd: OperandBytes must be within 1..8");
    end

    typedef enum logic [2:0] {IDLE, OPERANDS, MUL, SEND, NAK} state_t;

    state_t          state, state_nxt;
    logic            core_rst;
    logic            rx_valid;
    logic            opcode_ok;
    logic            timeout;
    logic            start_frame;
    logic [2:0]      op;
    logic [2*W-1:0]  opr, opr_nxt;
    logic [2*W-1:0]  prod, prod_corr;
    logic [W:0]      add_sum;
    logic [W-1:0]    a_op, b_op;
    logic [CntW-1:0] byte_cnt;
    logic [MulW-1:0] mul_cnt;
    logic [TmrW-1:0] tmr;

    uart_imul_cmd_if rx_if ();
    uart_imul_cmd_if tx_if ();

    assign core_rst     = !rst_ni;
    assign rx_if.tready = 1'b1;

    uart_rx u_rx (
        .clk      (clk_i),
        .rst      (core_rst),
        .prescale (Prescale),
        .rxd      (rx_i),
        .m_axis   (rx_if.master)
    );

    uart_tx u_tx (
        .clk      (clk_i),
        .rst      (core_rst),
        .prescale (Prescale),
        .txd      (tx_o),
        .s_axis   (tx_if.slave)
    );

    assign rx_valid    = rx_if.tvalid;
    assign opcode_ok   = (rx_if.tdata[7:3] == 5'd0);
    assign timeout     = (state == OPERANDS) && (tmr == '0);
    // a byte landing on the timeout cycle opens a new frame
    assign start_frame = rx_valid && opcode_ok && ((state == IDLE) || timeout);
    assign busy_o      = (state != IDLE);

    assign a_op    = opr[2*W-1:W];
    assign b_op    = opr[W-1:0];
    assign opr_nxt = {opr[2*W-9:0], rx_if.tdata};

    // unsigned shift-add: prod = {partial, multiplier}, one multiplier bit per cycle
    assign add_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_op} : {(W+1){1'b0}});

    // raw-pattern product minus 2^W times the other operand per negative signed input
    assign prod_corr = prod
                     - ((op[0] && a_op[W-1]) ? {b_op, {W{1'b0}}} : {(2*W){1'b0}})
                     - ((op[1] && b_op[W-1]) ? {a_op, {W{1'b0}}} : {(2*W){1'b0}});

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_if.tvalid = 1'b0;
        tx_if.tdata  = 8'h00;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    state_nxt = opcode_ok ? OPERANDS : NAK;
                end
            end
            OPERANDS: begin
                if (timeout) begin
                    if (rx_valid) begin
                        state_nxt = opcode_ok ? OPERANDS : NAK;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (rx_valid && byte_cnt == LastOpByte) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (mul_cnt == '0) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                tx_if.tvalid = 1'b1;
                tx_if.tdata  = op[2] ? prod[2*W-1 -: 8] : prod[W-1 -: 8];
                if (tx_if.tready && byte_cnt == LastTxByte) begin
                    state_nxt = IDLE;
                end
            end
            NAK: begin
                tx_if.tvalid = 1'b1;
                tx_if.tdata  = 8'hEE;
                if (tx_if.tready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op       <= '0;
            opr      <= '0;
            prod     <= '0;
            byte_cnt <= '0;
            mul_cnt  <= '0;
            tmr      <= '0;
            abort_o  <= 1'b0;
            drop_o   <= 1'b0;
        end else begin
            abort_o <= timeout;
            drop_o  <= rx_valid && (state == MUL || state == SEND || state == NAK);
            if (start_frame) begin
                op       <= rx_if.tdata[2:0];
                opr      <= '0;
                byte_cnt <= '0;
                tmr      <= TmrLoad;
            end else begin
                case (state)
                    OPERANDS: begin
                        if (!timeout) begin
                            if (rx_valid) begin
                                opr      <= opr_nxt;
                                byte_cnt <= byte_cnt + CntW'(1);
                                tmr      <= TmrLoad;
                                if (byte_cnt == LastOpByte) begin
                                    prod    <= {{W{1'b0}}, opr_nxt[W-1:0]};
                                    mul_cnt <= MulW'(W);
                                end
                            end else begin
                                tmr <= tmr - TmrW'(1);
                            end
                        end
                    end
                    MUL: begin
                        if (mul_cnt != '0) begin
                            prod    <= {add_sum, prod[W-1:1]};
                            mul_cnt <= mul_cnt - MulW'(1);
                        end else begin
                            prod     <= prod_corr;
                            byte_cnt <= '0;
                        end
                    end
                    SEND: begin
                        if (tx_if.tready) begin
                            prod     <= prod << 8;
                            byte_cnt <= byte_cnt + CntW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_imul_cmd.sv
// Directed bench for uart_imul_cmd: drives serial frames on rx, decodes
// the serial tx line into a byte log and compares against hand-computed
// products. A 1.8432 MHz clock keeps 115200 baud at 16 clocks per bit.
module tb_uart_imul_cmd;
    localparam int BitCycles = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic tx;
    logic busy;
    logic abort;
    logic drop;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_bytes [0:255];
    int         tx_n      = 0;
    int         drop_cnt  = 0;
    int         abort_cnt = 0;
    logic [7:0] mon_b;
    logic       mon_hit;

    always #5 clk = ~clk;

    uart_imul_cmd #(
        .DesiredBaudRate (115_200),
        .ClockFrequency  (1_843_200),
        .OperandBytes    (4),
        .TimeoutCycles   (1000)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .rx_i    (rx),
        .tx_o    (tx),
        .busy_o  (busy),
        .abort_o (abort),
        .drop_o  (drop)
    );

    // serial decoder; a byte that overlaps a reset is not logged
    always begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx === 1'b0) begin
            mon_hit = 1'b0;
            for (int k = 1; k <= 152; k++) begin
                @(negedge clk);
                if (rst_n !== 1'b1) mon_hit = 1'b1;
                if (k >= 24 && k <= 136 && ((k - 8) % 16) == 0) mon_b[3'((k - 24) / 16)] = tx;
            end
            if (!mon_hit) begin
                tx_bytes[8'(tx_n)] = mon_b;
                tx_n++;
            end
        end
    end

    always @(negedge clk) begin
        if (drop === 1'b1) drop_cnt++;
        if (abort === 1'b1) abort_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx = 1'b0;
        repeat (BitCycles) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BitCycles) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BitCycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
        send_byte(opc);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (tx_n >= n) break;
            @(negedge clk);
        end
        if (tx_n >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        tests++; if (tx !== 1'b1)    begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b expected 0", abort); end
        tests++; if (drop !== 1'b0)  begin fails++; $display("FAIL reset_drop: got %b expected 0", drop); end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
        tests++; if (tx_n !== 0)    begin fails++; $display("FAIL post_reset_tx_bytes: got %0d expected 0", tx_n); end
    endtask

    task automatic test_product(input string name, input logic [7:0] opc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        int          base, d0, a0;
        bit          ok;
        logic [31:0] got;
        base = tx_n; d0 = drop_cnt; a0 = abort_cnt;
        send_frame(opc, a, b);
        wait_bytes(base + 4, 3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s reply: got %0d bytes expected 4", name, tx_n - base);
        end else begin
            got = {tx_bytes[8'(base)], tx_bytes[8'(base + 1)], tx_bytes[8'(base + 2)], tx_bytes[8'(base + 3)]};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s result: got %h expected %h", name, got, exp);
            end
        end
        repeat (300) @(negedge clk);
        tests++; if (tx_n - base !== 4) begin fails++; $display("FAIL %s byte_count: got %0d expected 4", name, tx_n - base); end
        tests++; if (drop_cnt - d0 !== 0) begin fails++; $display("FAIL %s drop: got %0d pulses expected 0", name, drop_cnt - d0); end
        tests++; if (abort_cnt - a0 !== 0) begin fails++; $display("FAIL %s abort: got %0d pulses expected 0", name, abort_cnt - a0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_after: got %b expected 0", name, busy); end
    endtask

    task automatic test_nak();
        int  base;
        bit  ok;
        base = tx_n;
        send_byte(8'h41);
        wait_bytes(base + 1, 1000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL nak_reply: got %0d bytes expected 1", tx_n - base);
        end else begin
            tests++;
            if (tx_bytes[8'(base)] !== 8'hEE) begin
                fails++;
                $display("FAIL nak_byte: got %h expected ee", tx_bytes[8'(base)]);
            end
        end
        repeat (400) @(negedge clk);
        tests++; if (tx_n - base !== 1) begin fails++; $display("FAIL nak_count: got %0d expected 1", tx_n - base); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL nak_busy: got %b expected 0", busy); end
        test_product("after_nak", 8'h00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006);
    endtask

    task automatic test_timeout();
        int base, a0;
        base = tx_n; a0 = abort_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL timeout_busy_partial: got %b expected 1", busy); end
        repeat (1500) @(negedge clk);
        tests++; if (abort_cnt - a0 !== 1) begin fails++; $display("FAIL timeout_abort: got %0d pulses expected 1", abort_cnt - a0); end
        tests++; if (tx_n !== base) begin fails++; $display("FAIL timeout_tx: got %0d bytes expected 0", tx_n - base); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        test_product("after_timeout", 8'h00, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F);
    endtask

    task automatic test_reset_send();
        int base;
        bit ok;
        base = tx_n;
        send_frame(8'h00, 32'h1122_3344, 32'h0000_0001);
        wait_bytes(base + 2, 3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_send_first: got %0d bytes expected 2", tx_n - base);
        end else begin
            tests++;
            if ({tx_bytes[8'(base)], tx_bytes[8'(base + 1)]} !== 16'h1122) begin
                fails++;
                $display("FAIL rst_send_bytes: got %h%h expected 1122", tx_bytes[8'(base)], tx_bytes[8'(base + 1)]);
            end
        end
        // land inside the start bit of the third byte
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (tx !== 1'b1)   begin fails++; $display("FAIL rst_send_tx: got %b expected 1", tx); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_send_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2500) @(negedge clk);
        tests++; if (tx_n - base !== 2) begin fails++; $display("FAIL rst_send_count: got %0d expected 2", tx_n - base); end
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rst_send_idle_tx: got %b expected 1", tx); end
        test_product("after_reset", 8'h00, 32'h0000_0004, 32'h0000_0005, 32'h0000_0014);
    endtask

    task automatic test_drop();
        int          base, d0, a0;
        bit          ok;
        logic [31:0] got;
        base = tx_n; d0 = drop_cnt; a0 = abort_cnt;
        send_frame(8'h00, 32'h0000_0006, 32'h0000_0007);
        send_byte(8'hAA);
        send_byte(8'h55);
        wait_bytes(base + 4, 3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drop_reply: got %0d bytes expected 4", tx_n - base);
        end else begin
            got = {tx_bytes[8'(base)], tx_bytes[8'(base + 1)], tx_bytes[8'(base + 2)], tx_bytes[8'(base + 3)]};
            tests++;
            if (got !== 32'h0000_002A) begin
                fails++;
                $display("FAIL drop_result: got %h expected 0000002a", got);
            end
        end
        repeat (300) @(negedge clk);
        tests++; if (drop_cnt - d0 !== 2) begin fails++; $display("FAIL drop_pulses: got %0d expected 2", drop_cnt - d0); end
        tests++; if (abort_cnt - a0 !== 0) begin fails++; $display("FAIL drop_abort: got %0d expected 0", abort_cnt - a0); end
        tests++; if (tx_n - base !== 4) begin fails++; $display("FAIL drop_count: got %0d expected 4", tx_n - base); end
    endtask

    task automatic test_back_to_back();
        int          base, c;
        bit          ok;
        logic [31:0] got;
        base = tx_n;
        send_frame(8'h03, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
        c = 0;
        while (busy !== 1'b0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy %b expected 0", busy); end
        send_frame(8'h06, 32'h0000_0005, 32'h8000_0000);
        wait_bytes(base + 8, 3000, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_reply: got %0d bytes expected 8", tx_n - base);
        end else begin
            got = {tx_bytes[8'(base)], tx_bytes[8'(base + 1)], tx_bytes[8'(base + 2)], tx_bytes[8'(base + 3)]};
            tests++; if (got !== 32'h0000_0009) begin fails++; $display("FAIL b2b_first: got %h expected 00000009", got); end
            got = {tx_bytes[8'(base + 4)], tx_bytes[8'(base + 5)], tx_bytes[8'(base + 6)], tx_bytes[8'(base + 7)]};
            tests++; if (got !== 32'hFFFF_FFFD) begin fails++; $display("FAIL b2b_second: got %h expected fffffffd", got); end
        end
        repeat (300) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_product("basic",        8'h00, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);
        test_product("u_high_max",   8'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        test_product("s_high",       8'h07, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        test_product("s_low",        8'h03, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
        test_product("a_signed_low", 8'h01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);
        test_product("a_signed_hi",  8'h05, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
        test_product("a_unsig_hi",   8'h04, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002);
        test_product("b_signed_hi",  8'h06, 32'h0000_0005, 32'h8000_0000, 32'hFFFF_FFFD);
        test_product("carry_hi",     8'h04, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001);
        test_product("minneg_hi",    8'h07, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        test_nak();
        test_timeout();
        test_reset_send();
        test_drop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
